// File: rtl/instruction_decode_pipelined.sv
// RV32I instruction decode stage: register file with write-back bypass,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode_pipelined #(
    parameter int WIDTH     = 32,
    parameter int NUM_REGS  = 32,
    parameter int HAZARD_EN = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instruction_IFID,
    input  logic [WIDTH-1:0]            pc_IFID,
    input  logic [WIDTH-1:0]            pc_4_IFID,
    input  logic                        valid_IFID,
    input  logic [WIDTH-1:0]            reg_wr_data_WBID,
    input  logic [$clog2(NUM_REGS)-1:0] rd_WBID,
    input  logic                        reg_wr_en_WBID,
    input  logic                        flush_EX,
    input  logic                        stall_MEM,
    output logic                        stall_ID,
    output logic                        valid_IDEX,
    output logic                        illegal_IDEX,
    output logic [6:0]                  op_IDEX,
    output logic [2:0]                  funct3_IDEX,
    output logic [6:0]                  funct7_IDEX,
    output logic [$clog2(NUM_REGS)-1:0] rs1_IDEX,
    output logic [$clog2(NUM_REGS)-1:0] rs2_IDEX,
    output logic [$clog2(NUM_REGS)-1:0] rd_IDEX,
    output logic [WIDTH-1:0]            rs1_data_IDEX,
    output logic [WIDTH-1:0]            rs2_data_IDEX,
    output logic [WIDTH-1:0]            in1_IDEX,
    output logic [WIDTH-1:0]            in2_IDEX,
    output logic [WIDTH-1:0]            immediate_IDEX,
    output logic [WIDTH-1:0]            pc_IDEX,
    output logic [WIDTH-1:0]            pc_4_IDEX,
    output logic                        jump_branch_sel_IDEX,
    output logic                        mem_wr_en_IDEX,
    output logic                        mem_rd_en_IDEX,
    output logic                        reg_wr_en_IDEX,
    output logic [1:0]                  reg_wr_ctrl_IDEX
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic [6:0]       op;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
        logic [IDX_W-1:0] rd;
        logic [WIDTH-1:0] rs1_data;
        logic [WIDTH-1:0] rs2_data;
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pc_4;
        logic             jump_branch_sel;
        logic             mem_wr_en;
        logic             mem_rd_en;
        logic             reg_wr_en;
        logic [1:0]       reg_wr_ctrl;
    } idex_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    idex_t            idex_q;
    idex_t            idex_d;

    logic [IDX_W-1:0] rs1_idx;
    logic [IDX_W-1:0] rs2_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rs1_rdata;
    logic [WIDTH-1:0] rs2_rdata;
    logic             wb_wr_ok;

    imm_fmt_e          imm_fmt;
    logic signed [31:0] imm32;
    logic              legal;
    logic              in1_pc;
    logic              in1_zero;
    logic              in2_rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic              hazard;

    assign rs1_idx  = IDX_W'(instruction_IFID[19:15]);
    assign rs2_idx  = IDX_W'(instruction_IFID[24:20]);
    assign rd_idx   = IDX_W'(instruction_IFID[11:7]);
    assign wb_wr_ok = reg_wr_en_WBID && (rd_WBID != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_wr_ok) begin
            regs_q[rd_WBID] <= reg_wr_data_WBID;
        end
    end

    // Same-cycle write-back wins over the stored value so WB->ID needs no stall.
    always_comb begin
        rs1_rdata = regs_q[rs1_idx];
        if (rs1_idx == '0) begin
            rs1_rdata = '0;
        end else if (wb_wr_ok && (rd_WBID == rs1_idx)) begin
            rs1_rdata = reg_wr_data_WBID;
        end
        rs2_rdata = regs_q[rs2_idx];
        if (rs2_idx == '0) begin
            rs2_rdata = '0;
        end else if (wb_wr_ok && (rd_WBID == rs2_idx)) begin
            rs2_rdata = reg_wr_data_WBID;
        end
    end

    always_comb begin
        imm_fmt  = IMM_NONE;
        legal    = 1'b1;
        in1_pc   = 1'b0;
        in1_zero = 1'b0;
        in2_rs2  = 1'b0;
        use_rs1  = 1'b1;
        use_rs2  = 1'b0;
        idex_d   = '0;

        idex_d.valid    = valid_IFID;
        idex_d.op       = instruction_IFID[6:0];
        idex_d.funct3   = instruction_IFID[14:12];
        idex_d.funct7   = instruction_IFID[31:25];
        idex_d.rs1      = rs1_idx;
        idex_d.rs2      = rs2_idx;
        idex_d.rd       = rd_idx;
        idex_d.rs1_data = rs1_rdata;
        idex_d.rs2_data = rs2_rdata;
        idex_d.pc       = pc_IFID;
        idex_d.pc_4     = pc_4_IFID;

        case (instruction_IFID[6:0])
            OPC_OP: begin
                in2_rs2 = 1'b1;
                use_rs2 = 1'b1;
                idex_d.reg_wr_en = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_fmt = IMM_I;
                idex_d.reg_wr_en = 1'b1;
            end
            OPC_LOAD: begin
                imm_fmt = IMM_I;
                idex_d.mem_rd_en   = 1'b1;
                idex_d.reg_wr_en   = 1'b1;
                idex_d.reg_wr_ctrl = WB_MEM;
            end
            OPC_STORE: begin
                imm_fmt = IMM_S;
                use_rs2 = 1'b1;
                idex_d.mem_wr_en = 1'b1;
            end
            OPC_BRANCH: begin
                imm_fmt = IMM_B;
                in2_rs2 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LUI: begin
                imm_fmt  = IMM_U;
                in1_zero = 1'b1;
                use_rs1  = 1'b0;
                idex_d.reg_wr_en = 1'b1;
            end
            OPC_AUIPC: begin
                imm_fmt = IMM_U;
                in1_pc  = 1'b1;
                use_rs1 = 1'b0;
                idex_d.reg_wr_en = 1'b1;
            end
            OPC_JAL: begin
                imm_fmt = IMM_J;
                in1_pc  = 1'b1;
                use_rs1 = 1'b0;
                idex_d.jump_branch_sel = 1'b1;
                idex_d.reg_wr_en       = 1'b1;
                idex_d.reg_wr_ctrl     = WB_PC4;
            end
            OPC_JALR: begin
                imm_fmt = IMM_I;
                idex_d.jump_branch_sel = 1'b1;
                idex_d.reg_wr_en       = 1'b1;
                idex_d.reg_wr_ctrl     = WB_PC4;
            end
            default: legal = 1'b0;
        endcase

        case (imm_fmt)
            IMM_I:   imm32 = {{20{instruction_IFID[31]}}, instruction_IFID[31:20]};
            IMM_S:   imm32 = {{20{instruction_IFID[31]}}, instruction_IFID[31:25],
                              instruction_IFID[11:7]};
            IMM_B:   imm32 = {{19{instruction_IFID[31]}}, instruction_IFID[31],
                              instruction_IFID[7], instruction_IFID[30:25],
                              instruction_IFID[11:8], 1'b0};
            IMM_U:   imm32 = {instruction_IFID[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instruction_IFID[31]}}, instruction_IFID[31],
                              instruction_IFID[19:12], instruction_IFID[20],
                              instruction_IFID[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        idex_d.imm = WIDTH'(imm32);

        idex_d.in1 = in1_pc ? pc_IFID : (in1_zero ? '0 : rs1_rdata);
        idex_d.in2 = in2_rs2 ? rs2_rdata : idex_d.imm;

        // Illegal and non-valid slots must never cause side effects downstream.
        if (!legal) begin
            idex_d.illegal = valid_IFID;
        end
        if (!legal || !valid_IFID) begin
            idex_d.jump_branch_sel = 1'b0;
            idex_d.mem_wr_en       = 1'b0;
            idex_d.mem_rd_en       = 1'b0;
            idex_d.reg_wr_en       = 1'b0;
            idex_d.reg_wr_ctrl     = WB_ALU;
        end
    end

    always_comb begin
        hazard = (HAZARD_EN != 0) && valid_IFID && idex_q.valid && idex_q.mem_rd_en
                 && (idex_q.rd != '0)
                 && ((use_rs1 && (rs1_idx == idex_q.rd)) ||
                     (use_rs2 && (rs2_idx == idex_q.rd)));
        stall_ID = stall_MEM || (hazard && !flush_EX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idex_q <= '0;
        end else if (stall_MEM) begin
            idex_q <= idex_q;
        end else if (flush_EX || hazard) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign valid_IDEX           = idex_q.valid;
    assign illegal_IDEX         = idex_q.illegal;
    assign op_IDEX              = idex_q.op;
    assign funct3_IDEX          = idex_q.funct3;
    assign funct7_IDEX          = idex_q.funct7;
    assign rs1_IDEX             = idex_q.rs1;
    assign rs2_IDEX             = idex_q.rs2;
    assign rd_IDEX              = idex_q.rd;
    assign rs1_data_IDEX        = idex_q.rs1_data;
    assign rs2_data_IDEX        = idex_q.rs2_data;
    assign in1_IDEX             = idex_q.in1;
    assign in2_IDEX             = idex_q.in2;
    assign immediate_IDEX       = idex_q.imm;
    assign pc_IDEX              = idex_q.pc;
    assign pc_4_IDEX            = idex_q.pc_4;
    assign jump_branch_sel_IDEX = idex_q.jump_branch_sel;
    assign mem_wr_en_IDEX       = idex_q.mem_wr_en;
    assign mem_rd_en_IDEX       = idex_q.mem_rd_en;
    assign reg_wr_en_IDEX       = idex_q.reg_wr_en;
    assign reg_wr_ctrl_IDEX     = idex_q.reg_wr_ctrl;

endmodule

// File: tb/tb_instruction_decode_pipelined.sv
// Directed bench for instruction_decode_pipelined: reset, decode, bypass,
// load-use stall, flush/stall priority, JAL, store and illegal opcodes.
module tb_instruction_decode_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_IFID;
    logic [31:0] pc_IFID;
    logic [31:0] pc_4_IFID;
    logic        valid_IFID;
    logic [31:0] reg_wr_data_WBID;
    logic [4:0]  rd_WBID;
    logic        reg_wr_en_WBID;
    logic        flush_EX;
    logic        stall_MEM;
    logic        stall_ID;
    logic        valid_IDEX;
    logic        illegal_IDEX;
    logic [6:0]  op_IDEX;
    logic [2:0]  funct3_IDEX;
    logic [6:0]  funct7_IDEX;
    logic [4:0]  rs1_IDEX;
    logic [4:0]  rs2_IDEX;
    logic [4:0]  rd_IDEX;
    logic [31:0] rs1_data_IDEX;
    logic [31:0] rs2_data_IDEX;
    logic [31:0] in1_IDEX;
    logic [31:0] in2_IDEX;
    logic [31:0] immediate_IDEX;
    logic [31:0] pc_IDEX;
    logic [31:0] pc_4_IDEX;
    logic        jump_branch_sel_IDEX;
    logic        mem_wr_en_IDEX;
    logic        mem_rd_en_IDEX;
    logic        reg_wr_en_IDEX;
    logic [1:0]  reg_wr_ctrl_IDEX;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD_X6_X5_X0 = 32'h0002_8333;
    localparam logic [31:0] I_ADDI_X1_M5   = 32'hFFB0_0093;
    localparam logic [31:0] I_ADD_X4_X3_X3 = 32'h0031_8233;
    localparam logic [31:0] I_ADD_X7_X0_X0 = 32'h0000_03B3;
    localparam logic [31:0] I_LW_X2_0_X1   = 32'h0000_A103;
    localparam logic [31:0] I_ADD_X5_X2_X2 = 32'h0021_02B3;
    localparam logic [31:0] I_JAL_X1_8     = 32'h0080_00EF;
    localparam logic [31:0] I_SW_X2_M4_X1  = 32'hFE20_AE23;
    localparam logic [31:0] I_ILLEGAL      = 32'h0000_007F;

    instruction_decode_pipelined #(.WIDTH(32), .NUM_REGS(32), .HAZARD_EN(1)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_IFID     (instruction_IFID),
        .pc_IFID              (pc_IFID),
        .pc_4_IFID            (pc_4_IFID),
        .valid_IFID           (valid_IFID),
        .reg_wr_data_WBID     (reg_wr_data_WBID),
        .rd_WBID              (rd_WBID),
        .reg_wr_en_WBID       (reg_wr_en_WBID),
        .flush_EX             (flush_EX),
        .stall_MEM            (stall_MEM),
        .stall_ID             (stall_ID),
        .valid_IDEX           (valid_IDEX),
        .illegal_IDEX         (illegal_IDEX),
        .op_IDEX              (op_IDEX),
        .funct3_IDEX          (funct3_IDEX),
        .funct7_IDEX          (funct7_IDEX),
        .rs1_IDEX             (rs1_IDEX),
        .rs2_IDEX             (rs2_IDEX),
        .rd_IDEX              (rd_IDEX),
        .rs1_data_IDEX        (rs1_data_IDEX),
        .rs2_data_IDEX        (rs2_data_IDEX),
        .in1_IDEX             (in1_IDEX),
        .in2_IDEX             (in2_IDEX),
        .immediate_IDEX       (immediate_IDEX),
        .pc_IDEX              (pc_IDEX),
        .pc_4_IDEX            (pc_4_IDEX),
        .jump_branch_sel_IDEX (jump_branch_sel_IDEX),
        .mem_wr_en_IDEX       (mem_wr_en_IDEX),
        .mem_rd_en_IDEX       (mem_rd_en_IDEX),
        .reg_wr_en_IDEX       (reg_wr_en_IDEX),
        .reg_wr_ctrl_IDEX     (reg_wr_ctrl_IDEX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so outputs read here
    // reflect the edge just passed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        instruction_IFID = instr;
        pc_IFID          = pc;
        pc_4_IFID        = pc + 32'd4;
        valid_IFID       = 1'b1;
    endtask

    initial begin
        reset            = 1'b0;
        issue(I_ADDI_X1_M5, 32'h100);
        reg_wr_en_WBID   = 1'b1;
        rd_WBID          = 5'd5;
        reg_wr_data_WBID = 32'hDEAD_BEEF;
        flush_EX         = 1'b0;
        stall_MEM        = 1'b0;
        tick();
        tick();
        chk("rst_valid",   valid_IDEX, 0);
        chk("rst_rd",      rd_IDEX, 0);
        chk("rst_imm",     immediate_IDEX, 0);
        chk("rst_pc",      pc_IDEX, 0);
        chk("rst_regwr",   reg_wr_en_IDEX, 0);
        chk("rst_stall",   stall_ID, 0);

        reset          = 1'b1;
        reg_wr_en_WBID = 1'b0;
        issue(I_ADD_X6_X5_X0, 32'h80);
        tick();
        chk("x5_after_rst", rs1_data_IDEX, 0);
        chk("x5_in1",       in1_IDEX, 0);

        issue(I_ADDI_X1_M5, 32'h100);
        tick();
        chk("addi_imm",    immediate_IDEX, 32'hFFFF_FFFB);
        chk("addi_in2",    in2_IDEX, 32'hFFFF_FFFB);
        chk("addi_regwr",  reg_wr_en_IDEX, 1);
        chk("addi_wbctrl", reg_wr_ctrl_IDEX, 0);
        chk("addi_rd",     rd_IDEX, 1);
        chk("addi_valid",  valid_IDEX, 1);
        chk("addi_pc",     pc_IDEX, 32'h100);

        issue(I_ADD_X4_X3_X3, 32'h104);
        reg_wr_en_WBID   = 1'b1;
        rd_WBID          = 5'd3;
        reg_wr_data_WBID = 32'h0000_1234;
        tick();
        chk("byp_in1", in1_IDEX, 32'h1234);
        chk("byp_in2", in2_IDEX, 32'h1234);

        reg_wr_en_WBID = 1'b0;
        tick();
        chk("stored_x3", rs1_data_IDEX, 32'h1234);

        issue(I_ADD_X7_X0_X0, 32'h108);
        reg_wr_en_WBID   = 1'b1;
        rd_WBID          = 5'd0;
        reg_wr_data_WBID = 32'h0000_00FF;
        tick();
        chk("x0_byp_in1", in1_IDEX, 0);
        reg_wr_en_WBID = 1'b0;
        tick();
        chk("x0_stored", rs1_data_IDEX, 0);

        issue(I_LW_X2_0_X1, 32'h10C);
        tick();
        chk("lw_memrd", mem_rd_en_IDEX, 1);
        chk("lw_wbctrl", reg_wr_ctrl_IDEX, 1);
        issue(I_ADD_X5_X2_X2, 32'h110);
        #1;
        chk("lu_stall", stall_ID, 1);
        tick();
        chk("lu_bub_valid", valid_IDEX, 0);
        chk("lu_bub_regwr", reg_wr_en_IDEX, 0);
        chk("lu_bub_rd",    rd_IDEX, 0);
        chk("lu_stall_clr", stall_ID, 0);
        tick();
        chk("lu_add_valid", valid_IDEX, 1);
        chk("lu_add_rd",    rd_IDEX, 5);

        issue(I_LW_X2_0_X1, 32'h120);
        tick();
        issue(I_ADD_X5_X2_X2, 32'h124);
        flush_EX = 1'b1;
        #1;
        chk("fl_stall", stall_ID, 0);
        tick();
        chk("fl_bub_valid", valid_IDEX, 0);
        chk("fl_bub_pc",    pc_IDEX, 0);

        flush_EX = 1'b0;
        issue(I_LW_X2_0_X1, 32'h130);
        tick();
        issue(I_ADD_X5_X2_X2, 32'h134);
        flush_EX  = 1'b1;
        stall_MEM = 1'b1;
        #1;
        chk("sm_stall", stall_ID, 1);
        tick();
        chk("sm_hold_valid", valid_IDEX, 1);
        chk("sm_hold_memrd", mem_rd_en_IDEX, 1);
        chk("sm_hold_pc",    pc_IDEX, 32'h130);
        flush_EX  = 1'b0;
        stall_MEM = 1'b0;

        issue(I_JAL_X1_8, 32'h200);
        tick();
        chk("jal_in1",    in1_IDEX, 32'h200);
        chk("jal_imm",    immediate_IDEX, 8);
        chk("jal_jbs",    jump_branch_sel_IDEX, 1);
        chk("jal_wbctrl", reg_wr_ctrl_IDEX, 2);
        chk("jal_pc4",    pc_4_IDEX, 32'h204);
        chk("jal_regwr",  reg_wr_en_IDEX, 1);

        issue(I_SW_X2_M4_X1, 32'h300);
        tick();
        chk("sw_imm",   immediate_IDEX, 32'hFFFF_FFFC);
        chk("sw_memwr", mem_wr_en_IDEX, 1);
        chk("sw_regwr", reg_wr_en_IDEX, 0);

        issue(I_ILLEGAL, 32'h400);
        tick();
        chk("ill_flag",  illegal_IDEX, 1);
        chk("ill_valid", valid_IDEX, 1);
        chk("ill_regwr", reg_wr_en_IDEX, 0);
        chk("ill_memrd", mem_rd_en_IDEX, 0);
        chk("ill_memwr", mem_wr_en_IDEX, 0);
        chk("ill_jbs",   jump_branch_sel_IDEX, 0);

        issue(I_ADDI_X1_M5, 32'h500);
        valid_IFID = 1'b0;
        tick();
        chk("inv_valid", valid_IDEX, 0);
        chk("inv_regwr", reg_wr_en_IDEX, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
